// File: rtl/timebase_gen.sv
// Sample-timebase generator: run-time selectable clock-enable strobes with boundary-aligned rate switching.
// Optional external re-phase input (sync_in) is built only when TB_SYNC_EN is defined.
module timebase_gen #(
  parameter int                          NUM_RATES  = 4,
  parameter int                          SEL_W      = 2,
  parameter int                          DIV_W      = 20,
  parameter logic [NUM_RATES*DIV_W-1:0]  DIV_TABLE  = {20'd200000, 20'd2000, 20'd200, 20'd20},
  parameter int                          RESUME_DIV = 20
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             enable,
  input  logic [SEL_W-1:0] divisor,
`ifdef TB_SYNC_EN
  input  logic             sync_in,
`endif
  output logic             sample_tick,
  output logic             sample_clk,
  output logic             resume_tick,
  output logic [SEL_W-1:0] cur_sel,
  output logic             switch_busy
);

  localparam int RES_W = (RESUME_DIV > 2) ? $clog2(RESUME_DIV) : 1;

  // Divisors of 0 or 1 would make the wrap compare degenerate, so they are clamped to 2.
  function automatic logic [DIV_W-1:0] sat_div(input logic [SEL_W-1:0] sel);
    logic [DIV_W-1:0] raw;
    raw = DIV_TABLE[int'(sel)*DIV_W +: DIV_W];
    return (raw < DIV_W'(2)) ? DIV_W'(2) : raw;
  endfunction

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] div_cur;
  logic [SEL_W-1:0] pend_sel;
  logic [RES_W-1:0] res_cnt;
  logic             wrap;
  logic             rephase;
  logic             apply;
  logic             req_valid;
  logic             sync_rise;

`ifdef TB_SYNC_EN
  logic [2:0] sync_sh;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sync_sh <= '0;
    end else begin
      sync_sh <= {sync_sh[1:0], sync_in};
    end
  end

  assign sync_rise = sync_sh[1] & ~sync_sh[2];
`else
  assign sync_rise = 1'b0;
`endif

  always_comb begin
    div_cur   = sat_div(cur_sel);
    wrap      = enable && (cnt == div_cur - DIV_W'(1));
    rephase   = enable && sync_rise;
    // A pending switch lands only where a fresh period starts, so no period is cut or stretched.
    apply     = switch_busy && (wrap || !enable || rephase);
    cnt_nxt   = (!enable || wrap || rephase) ? '0 : cnt + DIV_W'(1);
    req_valid = int'(divisor) < NUM_RATES;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cnt         <= '0;
      sample_tick <= 1'b0;
      sample_clk  <= 1'b0;
      cur_sel     <= '0;
      pend_sel    <= '0;
      switch_busy <= 1'b0;
      res_cnt     <= '0;
      resume_tick <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      sample_tick <= wrap && !rephase;
      sample_clk  <= enable && (cnt_nxt < (div_cur >> 1));

      if (apply) begin
        cur_sel     <= pend_sel;
        switch_busy <= 1'b0;
      end else if (req_valid) begin
        if (divisor != cur_sel) begin
          pend_sel    <= divisor;
          switch_busy <= 1'b1;
        end else begin
          switch_busy <= 1'b0;
        end
      end

      if (res_cnt == RES_W'(RESUME_DIV - 1)) begin
        res_cnt     <= '0;
        resume_tick <= 1'b1;
      end else begin
        res_cnt     <= res_cnt + RES_W'(1);
        resume_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timebase_gen.sv
// Scoreboard bench for timebase_gen: per-edge expected outputs queued at drive time, popped after the edge.
// Re-phase scenario is exercised only when TB_SYNC_EN is defined.
module tb_timebase_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] divisor = '0;
  logic       sync_v = 1'b0;
  logic       sample_tick, sample_clk, resume_tick, switch_busy;
  logic [2:0] cur_sel;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       tick;
    logic       sclk;
    logic       res;
    logic [2:0] sel;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  // reference state
  int   tbl [4] = '{1, 4, 6, 9};
  int   m_cnt, m_r;
  logic [2:0] m_sel, m_pend;
  logic m_busy;
  logic h1, h2, h3;

  always #5 clk = ~clk;

  timebase_gen #(
    .NUM_RATES (4),
    .SEL_W     (3),
    .DIV_W     (8),
    .DIV_TABLE ({8'd9, 8'd6, 8'd4, 8'd1}),
    .RESUME_DIV(5)
  ) dut (
    .in_clk     (clk),
    .in_rst_n   (rst_n),
    .enable     (enable),
    .divisor    (divisor),
`ifdef TB_SYNC_EN
    .sync_in    (sync_v),
`endif
    .sample_tick(sample_tick),
    .sample_clk (sample_clk),
    .resume_tick(resume_tick),
    .cur_sel    (cur_sel),
    .switch_busy(switch_busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_r = 0; m_sel = '0; m_pend = '0; m_busy = 1'b0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    sb.delete();
  endtask

  // What one rising edge must produce, written from the behavioural rules.
  task automatic model_edge(input logic en, input logic [2:0] dv, input logic sy);
    exp_t e;
    int   d;
    logic rph, wr, app;
    d = tbl[m_sel];
    if (d < 2) d = 2;
    rph = en && h2 && !h3;
    wr  = en && (m_cnt == d - 1);
    app = m_busy && (wr || !en || rph);
    e = '0;
    if (!en) begin
      m_cnt = 0; e.tick = 1'b0; e.sclk = 1'b0;
    end else if (rph) begin
      m_cnt = 0; e.tick = 1'b0; e.sclk = 1'b1;
    end else if (wr) begin
      m_cnt = 0; e.tick = 1'b1; e.sclk = 1'b1;
    end else begin
      m_cnt = m_cnt + 1; e.tick = 1'b0; e.sclk = (m_cnt < d / 2);
    end
    if (app) begin
      m_sel = m_pend; m_busy = 1'b0;
    end else if (dv < 3'd4) begin
      if (dv != m_sel) begin
        m_pend = dv; m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end
    if (m_r == 4) begin
      m_r = 0; e.res = 1'b1;
    end else begin
      m_r = m_r + 1; e.res = 1'b0;
    end
    h3 = h2; h2 = h1; h1 = sy;
    e.sel  = m_sel;
    e.busy = m_busy;
    sb.push_back(e);
  endtask

  task automatic step(input logic en, input logic [2:0] dv, input logic sy);
    exp_t e;
    @(negedge clk);
    enable = en; divisor = dv; sync_v = sy;
`ifdef TB_SYNC_EN
    model_edge(en, dv, sy);
`else
    model_edge(en, dv, 1'b0);
`endif
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("tick", int'(sample_tick), int'(e.tick));
      chk("sclk", int'(sample_clk), int'(e.sclk));
      chk("resume", int'(resume_tick), int'(e.res));
      chk("cur_sel", int'(cur_sel), int'(e.sel));
      chk("busy", int'(switch_busy), int'(e.busy));
    end
  endtask

  task automatic wait_tick(input logic en, input logic [2:0] dv, input logic sy,
                           input int budget, output int n);
    n = 0;
    while (n < budget) begin
      step(en, dv, sy);
      n++;
      if (sample_tick) break;
    end
    if (!sample_tick) chk("tick_timeout", n, -1);
  endtask

  task automatic run_count(input int cycles, input logic [2:0] dv,
                           output int ticks, output int highs, output int res);
    ticks = 0; highs = 0; res = 0;
    for (int i = 0; i < cycles; i++) begin
      step(1'b1, dv, 1'b0);
      ticks += int'(sample_tick);
      highs += int'(sample_clk);
      res   += int'(resume_tick);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n, tk, hi, rs;
    model_reset();
    repeat (3) @(posedge clk);
    #4;
    chk("rst_tick", int'(sample_tick), 0);
    chk("rst_sclk", int'(sample_clk), 0);
    chk("rst_resume", int'(resume_tick), 0);
    chk("rst_sel", int'(cur_sel), 0);
    chk("rst_busy", int'(switch_busy), 0);
    rst_n = 1'b1;

    // 1) saturated divisor 1 -> period 2, 1/1 duty
    wait_tick(1'b1, 3'd0, 1'b0, 10, n);
    chk("t1_first", n, 2);
    run_count(8, 3'd0, tk, hi, rs);
    chk("t1_ticks", tk, 4);
    chk("t1_highs", hi, 4);

    // 2) switch to D=4 at the wrap
    step(1'b1, 3'd1, 1'b0);
    chk("t2_busy", int'(switch_busy), 1);
    wait_tick(1'b1, 3'd1, 1'b0, 10, n);
    chk("t2_sel", int'(cur_sel), 1);
    run_count(12, 3'd1, tk, hi, rs);
    chk("t2_ticks", tk, 3);
    chk("t2_highs", hi, 6);

    // 3) last request wins
    step(1'b1, 3'd3, 1'b0);
    wait_tick(1'b1, 3'd2, 1'b0, 10, n);
    chk("t3_sel", int'(cur_sel), 2);
    run_count(12, 3'd2, tk, hi, rs);
    chk("t3_ticks", tk, 2);
    chk("t3_highs", hi, 6);

    // 4) request then cancel
    step(1'b1, 3'd3, 1'b0);
    chk("t4_busy_set", int'(switch_busy), 1);
    step(1'b1, 3'd2, 1'b0);
    chk("t4_busy_clr", int'(switch_busy), 0);
    wait_tick(1'b1, 3'd2, 1'b0, 10, n);
    run_count(12, 3'd2, tk, hi, rs);
    chk("t4_ticks", tk, 2);
    chk("t4_sel", int'(cur_sel), 2);

    // 5) disable mid-period, switch while idle, re-enable
    repeat (3) step(1'b1, 3'd2, 1'b0);
    step(1'b0, 3'd2, 1'b0);
    chk("t5_tick_off", int'(sample_tick), 0);
    chk("t5_clk_off", int'(sample_clk), 0);
    step(1'b0, 3'd1, 1'b0);
    step(1'b0, 3'd1, 1'b0);
    chk("t5_idle_sel", int'(cur_sel), 1);
    step(1'b0, 3'd1, 1'b0);
    wait_tick(1'b1, 3'd1, 1'b0, 10, n);
    chk("t5_first", n, 4);
    run_count(20, 3'd1, tk, hi, rs);
    chk("t5_ticks", tk, 5);
    chk("t5_resume", rs, 4);

    // out-of-range selects are ignored
    step(1'b1, 3'd5, 1'b0);
    step(1'b1, 3'd7, 1'b0);
    chk("inv_busy", int'(switch_busy), 0);
    chk("inv_sel", int'(cur_sel), 1);

`ifdef TB_SYNC_EN
    // 6) re-phase at cnt=4 with D=9
    wait_tick(1'b1, 3'd3, 1'b0, 10, n);
    chk("t6_sel", int'(cur_sel), 3);
    repeat (4) step(1'b1, 3'd3, 1'b0);
    repeat (3) step(1'b1, 3'd3, 1'b1);
    chk("t6_rph_clk", int'(sample_clk), 1);
    chk("t6_rph_tick", int'(sample_tick), 0);
    wait_tick(1'b1, 3'd3, 1'b1, 20, n);
    chk("t6_next", n, 9);
`endif

    // asynchronous reset mid-run
    repeat (2) step(1'b1, 3'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tick", int'(sample_tick), 0);
    chk("arst_sclk", int'(sample_clk), 0);
    chk("arst_resume", int'(resume_tick), 0);
    chk("arst_sel", int'(cur_sel), 0);
    chk("arst_busy", int'(switch_busy), 0);
    model_reset();
    enable = 1'b0; sync_v = 1'b0; divisor = '0;
    rst_n = 1'b1;
    run_count(5, 3'd0, tk, hi, rs);
    chk("arst_resume_first", rs, 1);
    chk("arst_resume_last", int'(resume_tick), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
